// File: rtl/gshare_update_ctrl.sv
// gshare_update_ctrl
// Sits between fetch, branch resolution and the gshare pattern history table.
// Every prediction is queued in order with its PHT index, predicted direction
// and global-history snapshot. When the oldest branch resolves, exactly one
// PHT training command goes out over a valid/ready handshake. On a mispredict
// the younger queued branches are discarded, and the corrected history is sent
// back to the predictor.
module gshare_update_ctrl #(
  parameter int gshare_tam   = 10, // PHT index width and global-history width (>= 2)
  parameter int profundidade = 4,  // in-flight queue depth, power of 2, >= 2
  parameter int cont_tam     = 16  // statistics counter width
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic                            lookup_valid,
  input  logic [gshare_tam-1:0]           lookup_index,
  input  logic                            lookup_pred,
  input  logic [gshare_tam-1:0]           lookup_hist,
  output logic                            lookup_ready,

  input  logic                            resolve_valid,
  input  logic                            resolve_taken,
  output logic                            resolve_ready,

  output logic                            upd_valid,
  output logic [gshare_tam-1:0]           upd_index,
  output logic                            upd_taken,
  input  logic                            upd_ready,

  output logic                            flush,
  output logic                            hist_restore_valid,
  output logic [gshare_tam-1:0]           hist_restore,

  output logic [$clog2(profundidade):0]   queue_count,
  output logic [cont_tam-1:0]             br_count,
  output logic [cont_tam-1:0]             miss_count
);

  localparam int ptr_w = $clog2(profundidade);
  localparam int cnt_w = ptr_w + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  typedef struct packed {
    logic [gshare_tam-1:0] index;
    logic                  pred;
    logic [gshare_tam-1:0] hist;
  } entry_t;

  state_t                state_q, state_d;

  entry_t                mem [profundidade];
  logic [ptr_w-1:0]      wr_ptr, rd_ptr;
  logic [cnt_w-1:0]      count;
  logic                  full, empty;
  logic                  push, pop;
  entry_t                head;

  // Context of the branch currently being trained.
  logic [gshare_tam-1:0] upd_index_q;
  logic                  upd_taken_q;
  logic                  miss_q;
  logic [gshare_tam-1:0] hist_q;

  logic [cont_tam-1:0]   br_count_q, miss_count_q;

  // Occupancy flags and handshakes. The ready signals depend only on the
  // registered state, so a push into a full queue is refused even when a
  // pop happens in the same cycle.
  always_comb begin
    full          = (count == cnt_w'(profundidade));
    empty         = (count == '0);
    lookup_ready  = !rst && !full && (state_q != FLUSH);
    resolve_ready = !rst && !empty && (state_q == IDLE);
    push          = lookup_valid && lookup_ready;
    pop           = resolve_valid && resolve_ready;
    head          = mem[rd_ptr];
  end

  // Next state and the command/flush outputs, all decoded from the state.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    state_d            = state_q;
    upd_valid          = 1'b0;
    flush              = 1'b0;
    hist_restore_valid = 1'b0;
    hist_restore       = '0;
    unique case (state_q)
      IDLE: begin
        if (pop) state_d = UPDATE;
      end
      UPDATE: begin
        upd_valid = 1'b1;
        if (upd_ready) state_d = miss_q ? FLUSH : IDLE;
      end
      FLUSH: begin
        flush              = 1'b1;
        hist_restore_valid = 1'b1;
        hist_restore       = {hist_q[gshare_tam-2:0], upd_taken_q};
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the values from before this edge, whatever the statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Queue storage: written on an accepted lookup.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers and count decide
    // which entries are valid, so clearing the data would add logic for no benefit.
    if (push) mem[wr_ptr] <= '{index: lookup_index, pred: lookup_pred, hist: lookup_hist};
  end

  // Pointers and occupancy. FLUSH empties the queue by moving the read
  // pointer onto the write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (state_q == FLUSH) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Latch the context of the resolving branch. These registers hold steady for
  // the whole UPDATE state and any following FLUSH, because pop can only
  // happen in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_index_q <= '0;
      upd_taken_q <= 1'b0;
      miss_q      <= 1'b0;
      hist_q      <= '0;
    end else if (pop) begin
      upd_index_q <= head.index;
      upd_taken_q <= resolve_taken;
      miss_q      <= (head.pred != resolve_taken);
      hist_q      <= head.hist;
    end
  end

  // Saturating statistics counters, stepped once per accepted resolution.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else if (pop) begin
      if (br_count_q != '1) br_count_q <= br_count_q + 1'b1;
      if ((head.pred != resolve_taken) && (miss_count_q != '1))
        miss_count_q <= miss_count_q + 1'b1;
    end
  end

  assign upd_index   = upd_index_q;
  assign upd_taken   = upd_taken_q;
  assign queue_count = count;
  assign br_count    = br_count_q;
  assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_gshare_update_ctrl.sv
// Bench for gshare_update_ctrl: a cycle-by-cycle vector table for the basic,
// full-queue, mispredict and backpressure cases. After the table come
// hand-written sequences for pointer wrap, reset during UPDATE and counter
// saturation. A second instance with cont_tam = 2 receives the same stimulus
// and is used to check saturation.
module tb_gshare_update_ctrl;

  localparam int W  = 10;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          lookup_valid, lookup_pred, resolve_valid, resolve_taken, upd_ready;
  logic [W-1:0]  lookup_index, lookup_hist;

  logic          lookup_ready, resolve_ready, upd_valid, upd_taken, flush, hist_restore_valid;
  logic [W-1:0]  upd_index, hist_restore;
  logic [CW-1:0] queue_count;
  logic [15:0]   br_count, miss_count;

  logic          lookup_ready2, resolve_ready2, upd_valid2, upd_taken2, flush2, hrv2;
  logic [W-1:0]  upd_index2, hist_restore2;
  logic [CW-1:0] queue_count2;
  logic [1:0]    br_count2, miss_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gshare_update_ctrl #(.gshare_tam(W), .profundidade(D), .cont_tam(16)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index), .lookup_pred(lookup_pred),
    .lookup_hist(lookup_hist), .lookup_ready(lookup_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_ready(resolve_ready),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .flush(flush), .hist_restore_valid(hist_restore_valid), .hist_restore(hist_restore),
    .queue_count(queue_count), .br_count(br_count), .miss_count(miss_count)
  );

  gshare_update_ctrl #(.gshare_tam(W), .profundidade(D), .cont_tam(2)) dut2 (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index), .lookup_pred(lookup_pred),
    .lookup_hist(lookup_hist), .lookup_ready(lookup_ready2),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_ready(resolve_ready2),
    .upd_valid(upd_valid2), .upd_index(upd_index2), .upd_taken(upd_taken2), .upd_ready(upd_ready),
    .flush(flush2), .hist_restore_valid(hrv2), .hist_restore(hist_restore2),
    .queue_count(queue_count2), .br_count(br_count2), .miss_count(miss_count2)
  );

  typedef struct {
    logic          lv;  logic [W-1:0] li; logic lp; logic [W-1:0] lh;
    logic          rv;  logic rt; logic ur;
    logic          e_lr, e_rr, e_uv;
    logic [W-1:0]  e_ui; logic e_ut;
    logic          e_fl; logic [W-1:0] e_hr;
    logic [CW-1:0] e_qc;
    int            e_bc, e_mc;
  } vec_t;

  vec_t tbl[$];

  logic [W-1:0] exp_q[$];
  int pushed, resolved, updates, guard;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int lv, int li, int lp, int lh, int rv, int rt, int ur,
                              int lr, int rr, int uv, int ui, int ut, int fl, int hr,
                              int qc, int bc, int mc);
    vec_t v;
    v.lv = lv[0]; v.li = W'(li); v.lp = lp[0]; v.lh = W'(lh);
    v.rv = rv[0]; v.rt = rt[0]; v.ur = ur[0];
    v.e_lr = lr[0]; v.e_rr = rr[0]; v.e_uv = uv[0];
    v.e_ui = W'(ui); v.e_ut = ut[0]; v.e_fl = fl[0]; v.e_hr = W'(hr);
    v.e_qc = CW'(qc); v.e_bc = bc; v.e_mc = mc;
    return v;
  endfunction

  // Compare the state visible before this vector's inputs, then drive them.
  task automatic apply(input int i, input vec_t v);
    @(negedge clk);
    check($sformatf("v%0d lookup_ready", i), lookup_ready, v.e_lr);
    check($sformatf("v%0d resolve_ready", i), resolve_ready, v.e_rr);
    check($sformatf("v%0d upd_valid", i), upd_valid, v.e_uv);
    check($sformatf("v%0d flush", i), flush, v.e_fl);
    check($sformatf("v%0d hist_restore_valid", i), hist_restore_valid, v.e_fl);
    check($sformatf("v%0d queue_count", i), queue_count, v.e_qc);
    check($sformatf("v%0d br_count", i), br_count, v.e_bc);
    check($sformatf("v%0d miss_count", i), miss_count, v.e_mc);
    if (v.e_uv) begin
      check($sformatf("v%0d upd_index", i), upd_index, v.e_ui);
      check($sformatf("v%0d upd_taken", i), upd_taken, v.e_ut);
    end
    if (v.e_fl) check($sformatf("v%0d hist_restore", i), hist_restore, v.e_hr);
    lookup_valid = v.lv; lookup_index = v.li; lookup_pred = v.lp; lookup_hist = v.lh;
    resolve_valid = v.rv; resolve_taken = v.rt; upd_ready = v.ur;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " lookup_ready"}, lookup_ready, 0);
    check({tag, " resolve_ready"}, resolve_ready, 0);
    check({tag, " upd_valid"}, upd_valid, 0);
    check({tag, " upd_index"}, upd_index, 0);
    check({tag, " upd_taken"}, upd_taken, 0);
    check({tag, " flush"}, flush, 0);
    check({tag, " hist_restore_valid"}, hist_restore_valid, 0);
    check({tag, " hist_restore"}, hist_restore, 0);
    check({tag, " queue_count"}, queue_count, 0);
    check({tag, " br_count"}, br_count, 0);
    check({tag, " miss_count"}, miss_count, 0);
    check({tag, " dut2 idle outputs"},
          {lookup_ready2, resolve_ready2, upd_valid2, upd_taken2, flush2, hrv2}, 0);
    check({tag, " dut2 data outputs"},
          {upd_index2, hist_restore2, queue_count2, br_count2, miss_count2}, 0);
  endtask

  // One branch from push to return to IDLE, with upd_ready held high.
  task automatic run_branch(input logic [W-1:0] idx, input logic pred, input logic taken,
                            input logic [W-1:0] hist);
    int g;
    logic [W-1:0] exp_h;
    exp_h = {hist[W-2:0], taken};
    @(negedge clk);
    g = 0;
    while (!lookup_ready && g < 20) begin @(negedge clk); g++; end
    check("branch lookup_ready wait", lookup_ready, 1);
    lookup_valid = 1'b1; lookup_index = idx; lookup_pred = pred; lookup_hist = hist;
    @(negedge clk);
    lookup_valid = 1'b0;
    g = 0;
    while (!resolve_ready && g < 20) begin @(negedge clk); g++; end
    check("branch resolve_ready wait", resolve_ready, 1);
    resolve_valid = 1'b1; resolve_taken = taken;
    @(negedge clk);
    resolve_valid = 1'b0;
    check("branch upd_valid", upd_valid, 1);
    check("branch upd_index", upd_index, idx);
    if (pred != taken) begin
      @(negedge clk);
      check("branch flush", flush, 1);
      check("branch hist_restore", hist_restore, exp_h);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    lookup_valid = 1'b0; lookup_index = '0; lookup_pred = 1'b0; lookup_hist = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; upd_ready = 1'b1;

    // Single branch, full queue, mispredict, backpressure, empty resolve.
    tbl.push_back(mk(1,'h155,1,'h000, 0,0,1, 1,0,0,'h000,0,0,'h000, 0,0,0));
    tbl.push_back(mk(0,0,0,0,         1,1,1, 1,1,0,0,0,0,0,         1,0,0));
    tbl.push_back(mk(0,0,0,0,         0,0,1, 1,0,1,'h155,1,0,0,     0,1,0));
    tbl.push_back(mk(1,'h001,0,'h011, 0,0,1, 1,0,0,0,0,0,0,         0,1,0));
    tbl.push_back(mk(1,'h002,0,'h022, 0,0,1, 1,1,0,0,0,0,0,         1,1,0));
    tbl.push_back(mk(1,'h003,1,'h033, 0,0,1, 1,1,0,0,0,0,0,         2,1,0));
    tbl.push_back(mk(1,'h004,0,'h044, 0,0,1, 1,1,0,0,0,0,0,         3,1,0));
    tbl.push_back(mk(1,'h3FF,1,'h3FF, 0,0,1, 0,1,0,0,0,0,0,         4,1,0));
    tbl.push_back(mk(1,'h3FF,1,'h3FF, 1,0,1, 0,1,0,0,0,0,0,         4,1,0));
    tbl.push_back(mk(0,0,0,0,         0,0,1, 1,0,1,'h001,0,0,0,     3,2,0));
    tbl.push_back(mk(0,0,0,0,         1,0,1, 1,1,0,0,0,0,0,         3,2,0));
    tbl.push_back(mk(0,0,0,0,         0,0,1, 1,0,1,'h002,0,0,0,     2,3,0));
    tbl.push_back(mk(0,0,0,0,         1,1,1, 1,1,0,0,0,0,0,         2,3,0));
    tbl.push_back(mk(0,0,0,0,         0,0,1, 1,0,1,'h003,1,0,0,     1,4,0));
    tbl.push_back(mk(0,0,0,0,         1,0,1, 1,1,0,0,0,0,0,         1,4,0));
    tbl.push_back(mk(0,0,0,0,         0,0,1, 1,0,1,'h004,0,0,0,     0,5,0));
    tbl.push_back(mk(1,'h0A5,1,'h2AA, 0,0,1, 1,0,0,0,0,0,0,         0,5,0));
    tbl.push_back(mk(1,'h0B0,0,'h155, 0,0,1, 1,1,0,0,0,0,0,         1,5,0));
    tbl.push_back(mk(1,'h0C0,1,'h0AB, 0,0,1, 1,1,0,0,0,0,0,         2,5,0));
    tbl.push_back(mk(0,0,0,0,         1,0,1, 1,1,0,0,0,0,0,         3,5,0));
    tbl.push_back(mk(1,'h0D0,0,'h000, 0,0,1, 1,0,1,'h0A5,0,0,0,     2,6,1));
    tbl.push_back(mk(1,'h0E0,0,'h000, 0,0,1, 0,0,0,0,0,1,'h154,     3,6,1));
    tbl.push_back(mk(1,'h2C3,0,'h123, 0,0,1, 1,0,0,0,0,0,0,         0,6,1));
    tbl.push_back(mk(0,0,0,0,         1,0,0, 1,1,0,0,0,0,0,         1,6,1));
    tbl.push_back(mk(1,'h111,1,'h000, 1,1,0, 1,0,1,'h2C3,0,0,0,     0,7,1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,0,0,0,       1,1,0, 1,0,1,'h2C3,0,0,0,     1,7,1));
    tbl.push_back(mk(0,0,0,0,         1,1,1, 1,0,1,'h2C3,0,0,0,     1,7,1));
    tbl.push_back(mk(0,0,0,0,         0,0,1, 1,1,0,0,0,0,0,         1,7,1));
    tbl.push_back(mk(0,0,0,0,         1,1,1, 1,1,0,0,0,0,0,         1,7,1));
    tbl.push_back(mk(0,0,0,0,         0,0,1, 1,0,1,'h111,1,0,0,     0,8,1));
    tbl.push_back(mk(0,0,0,0,         1,0,1, 1,0,0,0,0,0,0,         0,8,1));
    tbl.push_back(mk(0,0,0,0,         0,0,1, 1,0,0,0,0,0,0,         0,8,1));

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    foreach (tbl[i]) apply(i, tbl[i]);

    // Wrap: each later push shares its cycle with a resolve accept.
    exp_q.delete();
    pushed = 0; resolved = 0; updates = 0; guard = 0;
    while (updates < 10 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (upd_valid) begin
        if (exp_q.size() == 0) check("wrap unexpected update", 0, 1);
        else check($sformatf("wrap upd_index #%0d", updates), upd_index, exp_q.pop_front());
        updates++;
      end
      check("wrap queue_count at most 1", queue_count <= 1, 1);
      lookup_valid = 1'b0; resolve_valid = 1'b0; upd_ready = 1'b1;
      if (pushed == 0 || (resolve_ready && resolved < 10)) begin
        if (pushed > 0) begin
          resolve_valid = 1'b1; resolve_taken = 1'(resolved % 2); resolved++;
        end
        if (pushed < 10) begin
          lookup_valid = 1'b1; lookup_index = W'(32'h080 + pushed * 37);
          lookup_pred = 1'(pushed % 2); lookup_hist = W'(pushed);
          exp_q.push_back(W'(32'h080 + pushed * 37));
          pushed++;
        end
      end
    end
    check("wrap update count", updates, 10);
    lookup_valid = 1'b0; resolve_valid = 1'b0;
    @(negedge clk);
    check("wrap br_count", br_count, 18);
    check("wrap miss_count", miss_count, 1);
    check("wrap queue_count", queue_count, 0);
    check("dut2 br_count saturated", br_count2, 3);
    check("dut2 miss_count", miss_count2, 1);

    // Reset while an update is waiting on upd_ready.
    lookup_valid = 1'b1; lookup_index = 10'h2F0; lookup_pred = 1'b0; lookup_hist = 10'h001;
    @(negedge clk);
    lookup_valid = 1'b0;
    check("rstmid resolve_ready", resolve_ready, 1);
    resolve_valid = 1'b1; resolve_taken = 1'b0; upd_ready = 1'b0;
    @(negedge clk);
    resolve_valid = 1'b0;
    check("rstmid upd_valid before reset", upd_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rstmid");
    rst = 1'b0; upd_ready = 1'b1;
    @(negedge clk);
    check("rstmid after lookup_ready", lookup_ready, 1);
    check("rstmid after resolve_ready", resolve_ready, 0);
    check("rstmid after upd_valid", upd_valid, 0);
    check("rstmid after queue_count", queue_count, 0);
    check("rstmid after br_count", br_count, 0);

    // Five mispredicts after reset: the 2-bit counters saturate at 3.
    for (int k = 0; k < 5; k++)
      run_branch(W'(32'h300 + k), 1'b1, 1'b0, W'(32'h201 + 3 * k));
    @(negedge clk);
    check("sat br_count", br_count, 5);
    check("sat miss_count", miss_count, 5);
    check("sat dut2 br_count", br_count2, 3);
    check("sat dut2 miss_count", miss_count2, 3);
    check("sat queue_count", queue_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
